// File: rtl/bcd_seg_driver.sv
// ============================================================================
// Module   : bcd_seg_driver
// Brief    : Sequential 8-bit binary to 3-digit BCD converter (double-dabble)
//            with registered active-low seven-segment outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seg_driver #(
    parameter logic BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic [6:0] seg2,
    output logic [6:0] seg1,
    output logic [6:0] seg0
);

    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_LZ    = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  shreg;
    logic [11:0] scratch;
    logic [2:0]  iter;
    logic [11:0] adj;
    logic [19:0] shifted;
    logic        blank2;
    logic        blank1;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Add-3 correction on every nibble before each shift.
    for (genvar i = 0; i < 3; i++) begin : g_adj
        assign adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ?
                               scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
    end

    assign shifted = {adj, shreg} << 1;
    assign blank2  = BLANK_LZ && (scratch[11:8] == 4'd0);
    assign blank1  = blank2 && (scratch[7:4] == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                busy = 1'b1;
                if (iter == 3'd7) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= 8'd0;
            scratch <= 12'd0;
            iter    <= 3'd0;
            done    <= 1'b0;
            bcd2    <= 4'd0;
            bcd1    <= 4'd0;
            bcd0    <= 4'd0;
            seg2    <= SEG_LZ;
            seg1    <= SEG_LZ;
            seg0    <= SEG_ZERO;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= value;
                        scratch <= 12'd0;
                        iter    <= 3'd0;
                    end
                end
                S_CONV: begin
                    {scratch, shreg} <= shifted;
                    iter             <= iter + 3'd1;
                end
                S_DONE: begin
                    bcd2 <= scratch[11:8];
                    bcd1 <= scratch[7:4];
                    bcd0 <= scratch[3:0];
                    seg2 <= blank2 ? SEG_BLANK : seg_enc(scratch[11:8]);
                    seg1 <= blank1 ? SEG_BLANK : seg_enc(scratch[7:4]);
                    seg0 <= seg_enc(scratch[3:0]);
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg_driver.sv
// ============================================================================
// Module   : tb_bcd_seg_driver
// Brief    : Directed self-checking bench for bcd_seg_driver (both blanking modes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_seg_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] value;

    logic       busy_a, done_a, busy_b, done_b;
    logic [3:0] bcd2_a, bcd1_a, bcd0_a, bcd2_b, bcd1_b, bcd0_b;
    logic [6:0] seg2_a, seg1_a, seg0_a, seg2_b, seg1_b, seg0_b;

    int total  = 0;
    int passed = 0;

    logic [6:0] tbl [10];

    always #5 clk = ~clk;

    bcd_seg_driver #(.BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy_a), .done(done_a),
        .bcd2(bcd2_a), .bcd1(bcd1_a), .bcd0(bcd0_a),
        .seg2(seg2_a), .seg1(seg1_a), .seg0(seg0_a)
    );

    bcd_seg_driver #(.BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy_b), .done(done_b),
        .bcd2(bcd2_b), .bcd1(bcd1_b), .bcd0(bcd0_b),
        .seg2(seg2_b), .seg1(seg1_b), .seg0(seg0_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
        chk({tag, "_bcd"},  {20'd0, bcd2_a, bcd1_a, bcd0_a}, 32'h000);
        chk({tag, "_seg_a"}, {11'd0, seg2_a, seg1_a, seg0_a}, {11'd0, 7'h7F, 7'h7F, 7'h40});
        chk({tag, "_seg_b"}, {11'd0, seg2_b, seg1_b, seg0_b}, {11'd0, 7'h40, 7'h40, 7'h40});
    endtask

    // Decimal reference: digits from / and %, segments from the table plus blanking rules.
    task automatic chk_result(input string tag, input int v);
        int h, t, o;
        logic [6:0] e2, e1;
        h  = v / 100;
        t  = (v / 10) % 10;
        o  = v % 10;
        e2 = (h == 0) ? 7'h7F : tbl[h];
        e1 = (h == 0 && t == 0) ? 7'h7F : tbl[t];
        chk({tag, "_bcd"}, {20'd0, bcd2_a, bcd1_a, bcd0_a}, {20'd0, 4'(h), 4'(t), 4'(o)});
        chk({tag, "_seg_a"}, {11'd0, seg2_a, seg1_a, seg0_a}, {11'd0, e2, e1, tbl[o]});
        chk({tag, "_seg_b"}, {11'd0, seg2_b, seg1_b, seg0_b}, {11'd0, tbl[h], tbl[t], tbl[o]});
    endtask

    // Accept at edge N, then count samples until done; done must appear after edge N+9.
    task automatic convert(input string tag, input int v, input bit full);
        int k;
        int bc;
        value = 8'(v);
        start = 1'b1;
        tick;
        start = 1'b0;
        value = ~8'(v);
        k  = 0;
        bc = 0;
        while (!done_a && k < 20) begin
            if (busy_a) bc++;
            tick;
            k++;
        end
        if (full) begin
            chk({tag, "_latency"}, k, 9);
            chk({tag, "_busy_cycles"}, bc, 9);
            chk({tag, "_busy_low_at_done"}, {31'd0, busy_a}, 32'd0);
        end else if (k != 9) begin
            chk({tag, "_latency"}, k, 9);
        end
        chk_result(tag, v);
        tick;
        if (full) chk({tag, "_done_pulse"}, {31'd0, done_a}, 32'd0);
    endtask

    initial begin
        int fib [14];
        int seen;
        fib = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

        reset = 1'b1;
        start = 1'b0;
        value = 8'd0;
        tick;
        tick;
        chk_reset_outputs("reset_held");
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done_a || busy_a) seen++;
        end
        chk("idle_20_no_activity", seen, 0);
        chk_reset_outputs("idle_20");

        convert("v255", 255, 1'b1);
        convert("v13", 13, 1'b1);
        convert("v0", 0, 1'b1);
        convert("v105", 105, 1'b1);

        // Back-to-back conversions with start held high; value scrambled while busy.
        start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            value = 8'(fib[i]);
            tick;
            value = 8'(fib[i] ^ 8'hA5);
            for (int j = 0; j < 8; j++) tick;
            chk($sformatf("fib%0d_no_early_done", i), {31'd0, done_a}, 32'd0);
            tick;
            chk($sformatf("fib%0d_done", i), {31'd0, done_a}, 32'd1);
            chk_result($sformatf("fib%0d", i), fib[i]);
        end
        start = 1'b0;
        tick;
        tick;

        // Reset pulsed during iteration 4 of a 200 conversion.
        value = 8'd200;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int j = 0; j < 4; j++) tick;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("abort_immediate");
        tick;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done_a) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk_reset_outputs("abort_after");
        convert("v200_after_abort", 200, 1'b1);

        // Reset coincident with start: no conversion begins.
        reset = 1'b1;
        start = 1'b1;
        value = 8'd77;
        tick;
        start = 1'b0;
        reset = 1'b0;
        tick;
        chk("reset_start_coincident_busy", {31'd0, busy_a}, 32'd0);
        chk_reset_outputs("reset_start_coincident");

        for (int v = 0; v < 256; v++) begin
            convert($sformatf("sweep%0d", v), v, 1'b0);
        end
        chk("sweep_no_x",
            {31'd0, $isunknown({busy_a, done_a, bcd2_a, bcd1_a, bcd0_a, seg2_a, seg1_a, seg0_a,
                                 busy_b, done_b, bcd2_b, bcd1_b, bcd0_b, seg2_b, seg1_b, seg0_b})},
            32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_seg_driver.md
# bcd_seg_driver

Sequential binary-to-BCD converter and seven-segment encoder that sits directly downstream of the Fibonacci sequence generator. It accepts the generator's 8-bit term on a start strobe and converts it with an iterative shift-add-3 (double-dabble) engine. It then drives three registered, active-low seven-segment digit outputs in decimal (hundreds, tens, ones), replacing the hex-per-nibble display path. Results are held stable between conversions.

## Interface

- `BLANK_LZ`, default 1: when 1, leading-zero digits are blanked. The ones digit is never blanked.
- `clk` input 1: system clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: conversion request; sampled only in IDLE.
- `value` input 8: unsigned binary operand; captured on the accepting edge only.
- `busy` output 1: high while a conversion is in progress (CONV or DONE state).
- `done` output 1: single-cycle pulse; new `bcd*`/`seg*` values are valid in the same cycle.
- `bcd2`, `bcd1`, `bcd0` output 4 each: hundreds, tens and ones BCD digits, registered. `bcd2` is at most 2.
- `seg2`, `seg1`, `seg0` output 7 each: active-low segments, bit0=a … bit6=g, registered.

## Operation

- States:
  - IDLE: accepts `start`.
  - CONV: 8 iterations.
  - DONE: 1 cycle, updates outputs.
- IDLE and `start`=1 at an edge:
  - Load the 8-bit shift register from `value`.
  - Clear the 12-bit BCD scratch register and the iteration counter.
  - Set `busy`=1 and go to CONV.
- CONV, each edge:
  - Every scratch nibble ≥5 gets +3 (combinationally, all nibbles in parallel).
  - Then shift {scratch, shiftreg} left by 1; the counter increments.
  - After the 8th iteration, go to DONE.
- DONE edge:
  - Copy scratch to `bcd2..0` and the encoded patterns to `seg2..0`.
  - Pulse `done`=1 for one cycle, set `busy`=0 and go to IDLE.
- `start` and `value` are ignored outside IDLE. A changing `value` during CONV has no effect on the result.
- Segment encoding, active-low hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - blank=7F
  - Any non-BCD nibble (unreachable) encodes as 7F.
- Blanking with `BLANK_LZ`=1:
  - `seg2`=7F if `bcd2`=0.
  - `seg1`=7F if `bcd2`=0 and `bcd1`=0.
  - `bcd*` outputs are never blanked.
- Outputs hold the last result indefinitely while IDLE.

## Timing

- Reset values:
  - State IDLE, `busy`=0, `done`=0.
  - `bcd2..0`=0.
  - `seg0`=40.
  - `seg1`=`seg2`=7F if `BLANK_LZ`=1, else 40.
  - Scratch, shift register and counter are all 0.
- Latency: if the accept occurs at edge N, iterations run on edges N+1..N+8 and the output update plus `done` occur at edge N+9.
- `busy` is high for cycles N+1..N+9, i.e. 9 cycles.
- `done` is high for exactly the cycle following edge N+9. During that cycle the state is already IDLE, so `start`=1 there is accepted at edge N+10.
- With `start` held high continuously, conversions occur back-to-back, with one `done` pulse every 10 cycles.
- Reset asserted mid-conversion:
  - Immediate abort to reset values.
  - No `done` is produced.
  - Previous results are lost (outputs return to reset values).
- Reset and `start` coincident: reset wins; no conversion is started.

## Test plan

- Reset release, no `start` for 20 cycles -> `busy`=0, `done`=0, `bcd`=0/0/0, `seg2`/`seg1`/`seg0`=7F/7F/40; same stimulus with `BLANK_LZ`=0 -> 40/40/40.
- `value`=255, one-cycle `start` -> `done` exactly 9 edges after acceptance, `bcd`=2/5/5, `seg`=24/12/12, `busy` high for 9 cycles.
- `value`=13, then `value`=0 (`BLANK_LZ`=1) -> 13 gives `bcd` 0/1/3 with `seg` 7F/79/30; 0 gives `seg` 7F/7F/40. With `value`=105 -> `seg` 79/40/12 (internal zero not blanked).
- `start` held high while driving the Fibonacci sequence 0,1,1,2,3,5,8,13,21,34,55,89,144,233 on `value` -> one `done` every 10 cycles; each result matches the value present at its acceptance edge; `value` changes during `busy` are ignored.
- Reset pulsed at iteration 4 of a 200 conversion -> outputs return to reset values immediately, no `done`; a following `start` with 200 yields 2/0/0 normally.
- Exhaustive sweep 0..255 against a decimal reference model -> all `bcd` and `seg` outputs match, with no X on any output.
